// File: rtl/xps2_keyq.sv
// PS/2 scan-code set 2 key queue: strips E0/F0 prefixes, maps calculator keys to 5-bit codes,
// and buffers them in a FIFO popped through a two-word memory-mapped read port.
module xps2_keyq #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              sel,
    input  logic              we,
    input  logic              addr,
    output logic [DATA_W-1:0] data_out,
    output logic              not_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = DEPTH[DEPTH_LOG2:0];

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [4:0]            mem_q [DEPTH];

    logic       flush, key_rd, stat_rd;
    logic       push_req, push, pop, full;
    logic [4:0] push_code;
    logic       map_hit;
    logic [4:0] map_code;

    assign flush   = sel & we & ~addr;
    assign key_rd  = sel & ~we & ~addr;
    assign stat_rd = sel & ~we & addr;
    assign full    = (count_q == COUNT_FULL);

    // Plain (non-extended) make-code translation.
    always_comb begin
        map_hit  = 1'b1;
        map_code = 5'h00;
        unique case (byte_in)
            8'h45, 8'h70: map_code = 5'h00;
            8'h16, 8'h69: map_code = 5'h01;
            8'h1E, 8'h72: map_code = 5'h02;
            8'h26, 8'h7A: map_code = 5'h03;
            8'h25, 8'h6B: map_code = 5'h04;
            8'h2E, 8'h73: map_code = 5'h05;
            8'h36, 8'h74: map_code = 5'h06;
            8'h3D, 8'h6C: map_code = 5'h07;
            8'h3E, 8'h75: map_code = 5'h08;
            8'h46, 8'h7D: map_code = 5'h09;
            8'h79:        map_code = 5'h0A;
            8'h7B:        map_code = 5'h0B;
            8'h7C:        map_code = 5'h0C;
            8'h5A:        map_code = 5'h0E;
            8'h66:        map_code = 5'h0F;
            8'h76:        map_code = 5'h10;
            default:      map_hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        push_code = map_code;
        if (byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (byte_in == 8'hE0)      state_d = StExt;
                    else if (byte_in == 8'hF0) state_d = StBrk;
                    else                       push_req = map_hit;
                end
                StExt: begin
                    state_d = StIdle;
                    if (byte_in == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (byte_in == 8'h4A) begin
                        push_req  = 1'b1;
                        push_code = 5'h0D;
                    end else if (byte_in == 8'h5A) begin
                        push_req  = 1'b1;
                        push_code = 5'h0E;
                    end
                end
                StBrk, StExtBrk: state_d = StIdle;
                default:         state_d = StIdle;
            endcase
        end
        if (flush) begin
            state_d  = StIdle;
            push_req = 1'b0;
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign pop  = key_rd & not_empty;
    assign push = push_req & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (flush)             count_d = '0;
        else if (push & ~pop)  count_d = count_q + 1'b1;
        else if (pop & ~push)  count_d = count_q - 1'b1;
    end

    // Set wins over the clear from a status read.
    always_comb begin
        overflow_d = overflow_q;
        if (stat_rd)                    overflow_d = 1'b0;
        if (push_req & full & ~pop)     overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            not_empty  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            not_empty  <= (count_d != '0);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    always_comb begin
        data_out = '0;
        if (key_rd && not_empty) begin
            data_out[DATA_W-1] = 1'b1;
            data_out[4:0]      = mem_q[rd_ptr_q];
        end else if (stat_rd) begin
            data_out[DEPTH_LOG2+4:0] = {count_q, 1'b0, overflow_q, full, not_empty};
        end
    end

endmodule

// File: tb/tb_xps2_keyq.sv
// Directed bench for xps2_keyq: byte streams in, key/status words checked against hand values.
module tb_xps2_keyq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] data_out;
    logic        not_empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xps2_keyq #(.DEPTH_LOG2(3), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .data_out   (data_out),
        .not_empty  (not_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // All stimulus is applied right after a falling edge; sampling happens 1ns later.
    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic rd(input logic a, output logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1 d = data_out;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic flush_wr();
        sel  = 1'b1;
        we   = 1'b1;
        addr = 1'b0;
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  fill [9];
        fill = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        #12 rst = 1'b1;
        @(negedge clk);
        #1 check("reset_data", data_out, 32'h0);
        check("reset_ne", {31'b0, not_empty}, 32'h0);
        @(negedge clk);

        // Single key
        send(8'h16);
        #1 check("single_ne", {31'b0, not_empty}, 32'h1);
        @(negedge clk);
        sel = 1'b0; addr = 1'b0;
        #1 check("nosel_zero", data_out, 32'h0);
        @(negedge clk);
        rd_chk("single_stat", 1'b1, 32'h11);
        rd_chk("single_key", 1'b0, 32'h8000_0001);
        rd_chk("single_stat2", 1'b1, 32'h00);
        rd_chk("empty_key", 1'b0, 32'h0);

        // Make/break
        send(8'h1E); send(8'hF0); send(8'h1E);
        rd_chk("mb_stat", 1'b1, 32'h11);
        rd_chk("mb_key", 1'b0, 32'h8000_0002);
        rd_chk("mb_stat2", 1'b1, 32'h00);

        // Extended codes, back-to-back strobes
        send(8'hE0); send(8'h4A); send(8'hE0); send(8'hF0); send(8'h4A);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h5A);
        rd_chk("ext_stat", 1'b1, 32'h21);
        rd_chk("ext_k0", 1'b0, 32'h8000_000D);
        rd_chk("ext_k1", 1'b0, 32'h8000_000E);

        // Keypad and function keys; unmapped/control bytes discarded
        send(8'h70); send(8'hAA); send(8'h79); send(8'h7B); send(8'hFA);
        send(8'h7C); send(8'h66); send(8'h76); send(8'h5A); send(8'h4A);
        rd_chk("kp_stat", 1'b1, 32'h71);
        rd_chk("kp_k0", 1'b0, 32'h8000_0000);
        rd_chk("kp_k1", 1'b0, 32'h8000_000A);
        rd_chk("kp_k2", 1'b0, 32'h8000_000B);
        rd_chk("kp_k3", 1'b0, 32'h8000_000C);
        rd_chk("kp_k4", 1'b0, 32'h8000_000F);
        rd_chk("kp_k5", 1'b0, 32'h8000_0010);
        rd_chk("kp_k6", 1'b0, 32'h8000_000E);
        rd_chk("kp_empty", 1'b1, 32'h00);

        // Overflow
        foreach (fill[i]) send(fill[i]);
        rd_chk("ovf_stat", 1'b1, 32'h87);
        rd_chk("ovf_stat2", 1'b1, 32'h83);
        // Status read coincident with an overflowing push: set wins
        byte_in = 8'h45; byte_valid = 1'b1;
        rd(1'b1, d);
        byte_valid = 1'b0;
        check("ovf_rdpush", d, 32'h83);
        rd_chk("ovf_set_wins", 1'b1, 32'h87);
        rd_chk("ovf_cleared", 1'b1, 32'h83);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("ovf_k%0d", i), 1'b0, 32'h8000_0001 + i);
        rd_chk("ovf_empty", 1'b1, 32'h00);

        // Full FIFO push and pop in the same cycle
        for (int i = 0; i < 8; i++) send(fill[i]);
        byte_in = 8'h45; byte_valid = 1'b1;
        rd(1'b0, d);
        byte_valid = 1'b0;
        check("fpp_key", d, 32'h8000_0001);
        rd_chk("fpp_stat", 1'b1, 32'h83);
        for (int i = 0; i < 7; i++) rd_chk($sformatf("fpp_k%0d", i), 1'b0, 32'h8000_0002 + i);
        rd_chk("fpp_last", 1'b0, 32'h8000_0000);
        rd_chk("fpp_empty", 1'b1, 32'h00);

        // Empty FIFO: read and push together; read returns 0, push lands
        byte_in = 8'h26; byte_valid = 1'b1;
        rd(1'b0, d);
        byte_valid = 1'b0;
        check("epp_key", d, 32'h0);
        rd_chk("epp_stat", 1'b1, 32'h11);
        rd_chk("epp_k", 1'b0, 32'h8000_0003);

        // Async reset mid-prefix
        send(8'hF0);
        #3 rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        send(8'h16);
        rd_chk("rst_stat", 1'b1, 32'h11);
        rd_chk("rst_k", 1'b0, 32'h8000_0001);

        // Flush with three entries queued
        send(8'h16); send(8'h1E); send(8'h26);
        rd_chk("fl_pre", 1'b1, 32'h31);
        flush_wr();
        rd_chk("fl_stat", 1'b1, 32'h00);

        // Flush forces IDLE: E0 then flush then 4A must not push 0x0D
        send(8'hE0);
        flush_wr();
        send(8'h4A);
        rd_chk("fl_fsm", 1'b1, 32'h00);

        // Flush coincident with a push: flush wins
        byte_in = 8'h16; byte_valid = 1'b1;
        flush_wr();
        byte_valid = 1'b0;
        rd_chk("fl_push", 1'b1, 32'h00);

        // Write to status address is ignored
        send(8'h46);
        sel = 1'b1; we = 1'b1; addr = 1'b1;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
        rd_chk("wr1_stat", 1'b1, 32'h11);
        rd_chk("wr1_k", 1'b0, 32'h8000_0009);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
